// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer for a single `mac` unit: one MAC op per (a,b) pair, partial sum chained via data_c.
// Optional bias pre-load per vector is enabled with `define MAC_BIAS_EN.
module mac_dot_ctrl #(
  parameter int A_BITWIDTH   = 8,
  parameter int OUT_BITWIDTH = 20,
  parameter int C_BITWIDTH   = OUT_BITWIDTH - 1,
  parameter int VEC_LEN      = 16,
  parameter int CNT_W        = $clog2(VEC_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [A_BITWIDTH-1:0]   in_a,
  input  logic [A_BITWIDTH-1:0]   in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_BITWIDTH-1:0] out_data,
  output logic                    out_ovf,
`ifdef MAC_BIAS_EN
  input  logic                    bias_valid,
  output logic                    bias_ready,
  input  logic [A_BITWIDTH-1:0]   bias,
`endif
  output logic                    mac_en,
  output logic                    mac_add,
  output logic [A_BITWIDTH-1:0]   mac_a,
  output logic [A_BITWIDTH-1:0]   mac_b,
  output logic [C_BITWIDTH-1:0]   mac_c,
  input  logic                    mac_done,
  input  logic [OUT_BITWIDTH-1:0] mac_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam logic signed [OUT_BITWIDTH-1:0] C_MAX = OUT_BITWIDTH'((1 << (C_BITWIDTH - 1)) - 1);
  localparam logic signed [OUT_BITWIDTH-1:0] C_MIN = ~C_MAX;

  logic [1:0]                     state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic signed [OUT_BITWIDTH-1:0] acc_q, acc_d;
  logic                           ovf_q, ovf_d;
  logic                           idle_q, idle_d;
  logic                           mac_en_q, mac_en_d;
  logic                           mac_add_q, mac_add_d;
  logic [A_BITWIDTH-1:0]          mac_a_q, mac_a_d;
  logic [A_BITWIDTH-1:0]          mac_b_q, mac_b_d;
  logic                           out_valid_q, out_valid_d;
  logic [OUT_BITWIDTH-1:0]        out_data_q, out_data_d;
  logic                           out_ovf_q, out_ovf_d;
  logic                           clamp_hi, clamp_lo;
`ifdef MAC_BIAS_EN
  logic                           bias_done_q, bias_done_d;
  logic                           bias_pending;
`endif

  assign clamp_hi = (acc_q > C_MAX);
  assign clamp_lo = (acc_q < C_MIN);

  always_comb begin
    mac_c = acc_q[C_BITWIDTH-1:0];
    if (clamp_hi) mac_c = C_MAX[C_BITWIDTH-1:0];
    if (clamp_lo) mac_c = C_MIN[C_BITWIDTH-1:0];
  end

  // idle_q mirrors state==IDLE but is held low during reset so in_ready reads 0 then.
`ifdef MAC_BIAS_EN
  assign bias_pending = !bias_done_q && (cnt_q == '0);
  assign bias_ready   = idle_q && !mac_done && bias_pending;
  assign in_ready     = idle_q && !mac_done && !bias_pending;
`else
  assign in_ready     = idle_q && !mac_done;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    mac_en_d    = mac_en_q;
    mac_add_d   = mac_add_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
`ifdef MAC_BIAS_EN
    bias_done_d = bias_done_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MAC_BIAS_EN
        if (bias_valid && bias_ready) begin
          mac_a_d     = bias;
          mac_b_d     = '0;
          mac_add_d   = 1'b1;
          mac_en_d    = 1'b1;
          bias_done_d = 1'b1;
          state_d     = ISSUE;
        end else
`endif
        if (in_valid && in_ready) begin
          mac_a_d   = in_a;
          mac_b_d   = in_b;
          mac_add_d = 1'b0;
          mac_en_d  = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (mac_done) begin
          acc_d    = mac_out;
          if (!mac_add_q) cnt_d = cnt_q + CNT_W'(1);
          if (clamp_hi || clamp_lo) ovf_d = 1'b1;
          mac_en_d = 1'b0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (!mac_done) begin
          if (cnt_q == CNT_W'(VEC_LEN)) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q;
            out_ovf_d   = ovf_q;
            state_d     = OUT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        if (out_ready) begin
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef MAC_BIAS_EN
          bias_done_d = 1'b0;
`endif
        end
      end
    endcase
    idle_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      idle_q      <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_add_q   <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
`ifdef MAC_BIAS_EN
      bias_done_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      idle_q      <= idle_d;
      mac_en_q    <= mac_en_d;
      mac_add_q   <= mac_add_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
`ifdef MAC_BIAS_EN
      bias_done_q <= bias_done_d;
`endif
    end
  end

  assign mac_en    = mac_en_q;
  assign mac_add   = mac_add_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Bench for mac_dot_ctrl: three instances (VEC_LEN 4, 20, 1), each driving a behavioural MAC with fixed latency.
// Results are compared against a dot-product model that applies the data_c clamp rule arithmetically.
module tb_mac_dot_ctrl;
  localparam int NI  = 3;
  localparam int LAT = 2;
  localparam int CMAX = (1 << 18) - 1;
  localparam int CMIN = -(1 << 18);

  logic clk, rstn;
  logic        in_valid [NI];
  logic        in_ready [NI];
  logic [7:0]  in_a     [NI];
  logic [7:0]  in_b     [NI];
  logic        out_valid[NI];
  logic        out_ready[NI];
  logic [19:0] out_data [NI];
  logic        out_ovf  [NI];
  logic        mac_en   [NI];
  logic        mac_add  [NI];
  logic [7:0]  mac_a    [NI];
  logic [7:0]  mac_b    [NI];
  logic [18:0] mac_c    [NI];
  logic        mac_done [NI];
  logic [19:0] mac_out  [NI];
  int          lat_cnt  [NI];
  logic        en_prev  [NI];
  int          en_pulses[NI];

  int n_cmp = 0;
  int n_err = 0;
  int pa[256];
  int pb[256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mac_dot_ctrl #(
      .A_BITWIDTH(8), .OUT_BITWIDTH(20), .VEC_LEN((g == 0) ? 4 : ((g == 1) ? 20 : 1))
    ) u_dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_a(in_a[g]), .in_b(in_b[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]), .out_ovf(out_ovf[g]),
      .mac_en(mac_en[g]), .mac_add(mac_add[g]), .mac_a(mac_a[g]), .mac_b(mac_b[g]), .mac_c(mac_c[g]),
      .mac_done(mac_done[g]), .mac_out(mac_out[g])
    );
  end

  // Behavioural MAC: done rises LAT cycles after enable and stays up until enable drops.
  always @(posedge clk or negedge rstn) begin
    for (int i = 0; i < NI; i++) begin
      if (!rstn) begin
        mac_done[i] <= 1'b0;
        mac_out[i]  <= '0;
        lat_cnt[i]  <= 0;
        en_prev[i]  <= 1'b0;
      end else begin
        en_prev[i] <= mac_en[i];
        if (mac_en[i] && !en_prev[i]) en_pulses[i] <= en_pulses[i] + 1;
        if (mac_en[i] && !mac_done[i]) begin
          if (lat_cnt[i] >= LAT) begin
            int r;
            r = mac_add[i] ? (int'($signed(mac_a[i])) * 256 + int'($signed(mac_c[i])))
                           : (int'($signed(mac_a[i])) * int'($signed(mac_b[i])) + int'($signed(mac_c[i])));
            mac_done[i] <= 1'b1;
            mac_out[i]  <= r[19:0];
          end else begin
            lat_cnt[i] <= lat_cnt[i] + 1;
          end
        end else if (!mac_en[i]) begin
          mac_done[i] <= 1'b0;
          lat_cnt[i]  <= 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int vl(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 20 : 1);
  endfunction

  function automatic logic [63:0] all_outs(input int d);
    return {4'b0, in_ready[d], out_valid[d], out_data[d], out_ovf[d], mac_en[d], mac_add[d],
            mac_a[d], mac_b[d], mac_c[d]};
  endfunction

  // Dot product where each step feeds the running sum through a 19-bit saturating clamp.
  task automatic ref_dot(input int n, output int res, output logic ovf);
    longint acc, c;
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      c = (acc > CMAX) ? CMAX : ((acc < CMIN) ? CMIN : acc);
      if (c != acc) ovf = 1'b1;
      acc = longint'(pa[i]) * longint'(pb[i]) + c;
    end
    res = int'(acc);
  endtask

  task automatic send_pair(input int d, input int a, input int b, input int maxgap);
    int t, gap;
    gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    for (int k = 0; k < gap; k++) begin
      in_valid[d] = 1'b0;
      @(negedge clk);
    end
    in_valid[d] = 1'b1;
    in_a[d] = a[7:0];
    in_b[d] = b[7:0];
    t = 0;
    while (!in_ready[d] && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("in_ready_timeout", 64'(t), 64'(0));
    @(negedge clk);
  endtask

  task automatic get_result(input int d, input int hold, output logic [19:0] data, output logic ovf);
    int t, p0;
    out_ready[d] = 1'b0;
    t = 0;
    while (!out_valid[d] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_seen", 64'(out_valid[d]), 64'(1));
    data = out_data[d];
    ovf  = out_ovf[d];
    p0   = en_pulses[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_data", 64'(out_data[d]), 64'(data));
      check("hold_in_ready", 64'(in_ready[d]), 64'(0));
      check("hold_mac_idle", 64'({mac_en[d], 31'(en_pulses[d] - p0)}), 64'(0));
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check("out_valid_drop", 64'(out_valid[d]), 64'(0));
  endtask

  task automatic run_vec(input int d, input int maxgap, input int hold, input string tag);
    int n, p0, exp_res;
    logic exp_ovf, got_ovf;
    logic [19:0] got;
    n  = vl(d);
    p0 = en_pulses[d];
    for (int i = 0; i < n; i++) send_pair(d, pa[i], pb[i], maxgap);
    in_valid[d] = 1'b0;
    get_result(d, hold, got, got_ovf);
    ref_dot(n, exp_res, exp_ovf);
    check({tag, "_data"}, 64'(got), 64'(exp_res[19:0]));
    check({tag, "_ovf"}, 64'(got_ovf), 64'(exp_ovf));
    check({tag, "_pulses"}, 64'(en_pulses[d] - p0), 64'(n));
  endtask

  task automatic load_basic();
    pa[0] = 1;  pb[0] = 2;
    pa[1] = 3;  pb[1] = 4;
    pa[2] = -5; pb[2] = 6;
    pa[3] = 7;  pb[3] = -8;
  endtask

  initial begin
    logic [19:0] lit;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0; out_ready[i] = 1'b0; en_pulses[i] = 0;
    end
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #3;
    for (int i = 0; i < NI; i++) check("reset_outputs", all_outs(i), 64'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready[0]), 64'(1));

    // Back-to-back basic vector, then the same with a long output stall.
    load_basic();
    run_vec(0, 0, 0, "basic");
    lit = 20'hFFFB8;
    check("basic_literal", 64'(out_data[0]), 64'(lit));
    run_vec(0, 0, 10, "stall");

    // Saturation on the 20-element instance, then a clean follow-up vector.
    for (int i = 0; i < 20; i++) begin pa[i] = -128; pb[i] = -128; end
    run_vec(1, 0, 2, "clamp");
    check("clamp_literal", 64'(out_data[1]), 64'(278527));
    for (int i = 0; i < 20; i++) begin pa[i] = 1; pb[i] = 1; end
    run_vec(1, 0, 0, "ones");

    // Random gaps in in_valid.
    load_basic();
    run_vec(0, 3, 1, "gaps");

    // VEC_LEN = 1 boundary.
    pa[0] = -128; pb[0] = 127;
    run_vec(2, 1, 1, "len1");

    // Reset asserted while pair 3 is being issued.
    load_basic();
    send_pair(0, pa[0], pb[0], 0);
    send_pair(0, pa[1], pb[1], 0);
    send_pair(0, pa[2], pb[2], 0);
    in_valid[0] = 1'b0;
    check("issue_before_rst", 64'(mac_en[0]), 64'(1));
    #2 rstn = 1'b0;
    #1 check("rst_mid_outputs", all_outs(0), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin pa[i] = 2; pb[i] = 3; end
    run_vec(0, 0, 0, "after_rst");

    // Random operand vectors on every instance.
    for (int r = 0; r < 6; r++) begin
      int d;
      d = r % NI;
      for (int i = 0; i < vl(d); i++) begin
        pa[i] = int'($urandom_range(0, 255)) - 128;
        pb[i] = int'($urandom_range(0, 255)) - 128;
      end
      run_vec(d, 2, int'($urandom_range(0, 3)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1, "timeout");
  end

endmodule
